// File: rtl/sram_image_loader.sv
// sram_image_loader: runs the SRAM zero-fill engine, then streams (addr, data) image records
// into the same SRAM port, holding the core in runstall until the image is loaded.
module sram_image_loader #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_abort,
    output logic              load_busy,
    output logic              load_done,
    output logic              runstall,
    output logic              sram_init,
    input  logic              sram_init_done,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_en,
    input  logic              init_wr,
    input  logic [DATA_W-1:0] init_wdata,
    input  logic              rec_valid,
    output logic              rec_ready,
    input  logic [ADDR_W-1:0] rec_addr,
    input  logic [DATA_W-1:0] rec_data,
    input  logic              rec_last,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic [CNT_W-1:0]  rec_count
);
    typedef enum logic [1:0] {IDLE, INIT, LOAD, DONE} state_t;
    state_t state, state_nx;
    logic last_seen, wr_pend, accept, start;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    always_comb begin
        state_nx = state;
        if (load_abort)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = load_start ? INIT : IDLE;
                INIT:    state_nx = sram_init_done ? LOAD : INIT;
                LOAD:    state_nx = last_seen ? DONE : LOAD;
                DONE:    state_nx = load_start ? INIT : DONE;
                default: state_nx = IDLE;
            endcase
        start      = load_start && !load_abort && (state == IDLE || state == DONE);
        rec_ready  = state == LOAD && !last_seen && !load_abort;
        accept     = rec_ready && rec_valid;
        load_busy  = state == INIT || state == LOAD;
        load_done  = state == DONE;
        runstall   = state != DONE;
        // The engine owns the port only while filling; otherwise the write register drives it.
        sram_addr  = state == INIT ? init_addr  : wr_addr;
        sram_wdata = state == INIT ? init_wdata : wr_data;
        sram_en    = state == INIT ? init_en    : wr_pend;
        sram_wr    = state == INIT ? init_wr    : wr_pend;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sram_init <= 1'b0;
            last_seen <= 1'b0;
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rec_count <= '0;
        end else begin
            state     <= state_nx;
            sram_init <= state_nx == INIT;
            wr_pend   <= accept;
            if (accept) begin
                wr_addr <= rec_addr;
                wr_data <= rec_data;
            end
            last_seen <= start ? 1'b0 : last_seen | (accept & rec_last);
            rec_count <= start ? '0 : (accept && !(&rec_count)) ? rec_count + CNT_W'(1) : rec_count;
        end
    end
endmodule

// File: tb/tb_sram_image_loader.sv
// tb_sram_image_loader: directed table-driven checks of the SRAM image loader.
module tb_sram_image_loader;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int CW = 16;

    logic clk = 0, reset = 1;
    logic load_start = 0, load_abort = 0, load_busy, load_done, runstall, sram_init;
    logic sram_init_done = 0, init_en = 0, init_wr = 0, rec_valid = 0, rec_ready, rec_last = 0;
    logic [AW-1:0] init_addr = '0, rec_addr = '0, sram_addr;
    logic [DW-1:0] init_wdata = '0, rec_data = '0, sram_wdata;
    logic sram_en, sram_wr;
    logic [CW-1:0] rec_count;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    sram_image_loader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_abort(load_abort),
        .load_busy(load_busy), .load_done(load_done), .runstall(runstall), .sram_init(sram_init),
        .sram_init_done(sram_init_done), .init_addr(init_addr), .init_en(init_en), .init_wr(init_wr),
        .init_wdata(init_wdata), .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_addr(rec_addr),
        .rec_data(rec_data), .rec_last(rec_last), .sram_addr(sram_addr), .sram_en(sram_en),
        .sram_wr(sram_wr), .sram_wdata(sram_wdata), .rec_count(rec_count)
    );

    typedef struct {
        logic st, ab, v, l;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic er, een, eb, edn, ers, ei;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        int ec;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic st, ab, v, l, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic er, een, eb, edn, ers, ei, input logic [AW-1:0] ea,
                                input logic [DW-1:0] ed, input int ec);
        tbl.push_back('{st, ab, v, l, a, d, er, een, eb, edn, ers, ei, ea, ed, ec});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            load_start = tbl[i].st; load_abort = tbl[i].ab; rec_valid = tbl[i].v;
            rec_last = tbl[i].l; rec_addr = tbl[i].a; rec_data = tbl[i].d;
            @(negedge clk);
            check($sformatf("row%0d_ready", i), rec_ready, tbl[i].er);
            check($sformatf("row%0d_en", i), sram_en, tbl[i].een);
            check($sformatf("row%0d_wr", i), sram_wr, tbl[i].een);
            check($sformatf("row%0d_busy", i), load_busy, tbl[i].eb);
            check($sformatf("row%0d_done", i), load_done, tbl[i].edn);
            check($sformatf("row%0d_runstall", i), runstall, tbl[i].ers);
            check($sformatf("row%0d_init", i), sram_init, tbl[i].ei);
            check($sformatf("row%0d_addr", i), 32'(sram_addr), 32'(tbl[i].ea));
            check($sformatf("row%0d_data", i), sram_wdata, tbl[i].ed);
            check($sformatf("row%0d_count", i), 32'(rec_count), tbl[i].ec);
            @(posedge clk); #1;
        end
        load_start = 0; load_abort = 0; rec_valid = 0; rec_last = 0;
    endtask

    // Zero-fill engine model: entered on the first INIT cycle, leaves the loader in LOAD.
    task automatic do_init(input int n);
        int errs = 0;
        rec_valid = 1;
        check("init_sram_init", sram_init, 1);
        check("init_runstall", runstall, 1);
        check("init_busy", load_busy, 1);
        check("init_count", 32'(rec_count), 0);
        check("init_ready", rec_ready, 0);
        for (int i = 0; i < n; i++) begin
            init_en = (i % 5) != 3; init_wr = i[0]; init_addr = AW'(i); init_wdata = 32'(i) ^ 32'hA5A5_0000;
            @(negedge clk);
            if (sram_en !== init_en || sram_wr !== init_wr || sram_addr !== init_addr ||
                sram_wdata !== init_wdata || sram_init !== 1'b1 || rec_ready !== 1'b0) errs++;
            @(posedge clk); #1;
        end
        check("init_passthru_errs", errs, 0);
        rec_valid = 0; init_en = 0; sram_init_done = 1;
        @(posedge clk); #1;
        sram_init_done = 0;
        check("load_sram_init", sram_init, 0);
        check("load_busy", load_busy, 1);
        init_en = 1; init_wr = 1; init_addr = 15'h1234; init_wdata = 32'hCAFE_F00D;
    endtask

    initial begin
        add(0,0,1,0,'h10,'hDEADBEEF, 1,0,1,0,1,0, 'h0,'h0,0);
        add(0,0,1,0,'h11,'h12345678, 1,1,1,0,1,0, 'h10,'hDEADBEEF,1);
        add(0,0,1,1,'h7FFF,'h1,      1,1,1,0,1,0, 'h11,'h12345678,2);
        add(0,0,0,0,0,0,             0,1,1,0,1,0, 'h7FFF,'h1,3);
        add(0,0,0,0,0,0,             0,0,0,1,0,0, 'h7FFF,'h1,3);
        add(1,0,0,0,0,0,             0,0,0,1,0,0, 'h7FFF,'h1,3);
        add(0,0,1,0,'h20,'hA,        1,0,1,0,1,0, 'h7FFF,'h1,0);
        add(0,0,0,0,0,0,             1,1,1,0,1,0, 'h20,'hA,1);
        add(0,0,0,0,0,0,             1,0,1,0,1,0, 'h20,'hA,1);
        add(0,0,1,1,'h20,'hB,        1,0,1,0,1,0, 'h20,'hA,1);
        add(0,0,0,0,0,0,             0,1,1,0,1,0, 'h20,'hB,2);
        add(0,0,0,0,0,0,             0,0,0,1,0,0, 'h20,'hB,2);
        add(1,0,0,0,0,0,             0,0,0,1,0,0, 'h20,'hB,2);
        add(0,0,1,0,'h30,'h33,       1,0,1,0,1,0, 'h20,'hB,0);
        add(0,1,1,0,'h31,'h44,       0,1,1,0,1,0, 'h30,'h33,1);
        add(0,0,1,0,'h32,'h55,       0,0,0,0,1,0, 'h30,'h33,1);
        add(1,1,0,0,0,0,             0,0,0,0,1,0, 'h30,'h33,1);
        add(0,0,0,0,0,0,             0,0,0,0,1,0, 'h30,'h33,1);
        add(1,0,0,0,0,0,             0,0,0,0,1,0, 'h30,'h33,1);
        add(0,0,1,1,'h1,'h55AA55AA,  1,0,1,0,1,0, 'h30,'h33,0);
        add(0,0,0,0,0,0,             0,1,1,0,1,0, 'h1,'h55AA55AA,1);
        add(0,0,0,0,0,0,             0,0,0,1,0,0, 'h1,'h55AA55AA,1);

        rec_valid = 1;
        #12;
        check("rst_runstall", runstall, 1);
        check("rst_en", sram_en, 0);
        check("rst_init", sram_init, 0);
        check("rst_ready", rec_ready, 0);
        check("rst_count", 32'(rec_count), 0);
        check("rst_done", load_done, 0);
        reset = 0;
        @(posedge clk); #1;
        check("idle_ready", rec_ready, 0);
        check("idle_busy", load_busy, 0);
        rec_valid = 0; load_start = 1;
        @(posedge clk); #1;
        load_start = 0;
        do_init(32768);
        run(0, 5);
        do_init(16);
        run(6, 12);
        do_init(8);
        run(13, 18);
        do_init(4);
        run(19, 21);
        check("pre_rst_done", load_done, 1);
        #2 reset = 1;
        #1;
        check("async_rst_done", load_done, 0);
        check("async_rst_runstall", runstall, 1);
        check("async_rst_count", 32'(rec_count), 0);
        check("async_rst_busy", load_busy, 0);
        #1 reset = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_image_loader.md
Name: sram_image_loader

Overview:
- Sequences SRAM bring-up for the Xtensa core: starts the zero-fill engine, waits for it to finish, then writes a sparse stream of (address, data) image records into the same SRAM port.
- Sits directly downstream of the SRAM zero-fill engine. It drives that engine's sram_init and consumes its sram_init_done and write port.
- Muxes that port with its own record writes onto the single SRAM port and holds the core in runstall until the image is loaded.

Parameters:
- ADDR_W, 15, SRAM word-address width (must equal the init engine's address width).
- DATA_W, 32, SRAM word width.
- CNT_W, 16, width of the accepted-record counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_start  input  1  one-cycle pulse that begins init and load.
- load_abort  input  1  one-cycle pulse that returns to IDLE from any state.
- load_busy  output  1  high in INIT or LOAD.
- load_done  output  1  high in DONE.
- runstall  output  1  core stall; high except in DONE.
- sram_init  output  1  request to the zero-fill engine.
- sram_init_done  input  1  zero-fill complete, from the engine.
- init_addr  input  ADDR_W  engine address.
- init_en  input  1  engine enable.
- init_wr  input  1  engine write strobe.
- init_wdata  input  DATA_W  engine data.
- rec_valid  input  1  image record valid.
- rec_ready  output  1  image record accepted when rec_valid and rec_ready are both high.
- rec_addr  input  ADDR_W  record word address.
- rec_data  input  DATA_W  record data.
- rec_last  input  1  marks the final record.
- sram_addr  output  ADDR_W  muxed SRAM address.
- sram_en  output  1  muxed SRAM enable.
- sram_wr  output  1  muxed SRAM write.
- sram_wdata  output  DATA_W  muxed SRAM data.
- rec_count  output  CNT_W  number of records accepted since the last load_start.

Behaviour:
- States: IDLE, INIT, LOAD, DONE. Reset value is IDLE.
- Reset values: all outputs 0 except runstall=1. The write register and rec_count are cleared.
- IDLE -> INIT on load_start. rec_count clears on the same edge.
- INIT:
  - sram_init=1, registered from state.
  - The SRAM port passes init_addr, init_en, init_wr and init_wdata through combinationally.
  - INIT -> LOAD on the first cycle sram_init_done=1 is sampled.
- LOAD:
  - sram_init=0, which lets the engine return to its idle state.
  - rec_ready = (state==LOAD) && !last_seen && !load_abort. This is combinational, so one record can be accepted per cycle.
  - On accept, the write register captures rec_addr and rec_data. sram_en=1, sram_wr=1 and sram_addr/sram_wdata equal the captured values on the next cycle only, giving exactly 1-cycle latency.
  - With no accept, sram_en=0, and sram_addr/sram_wdata hold their last values.
  - The init_* inputs are ignored in LOAD.
- rec_count increments on each accept and saturates at all-ones, with no wrap.
- Accepting a record with rec_last=1 sets last_seen. The state moves LOAD -> DONE one cycle after the last write issues, so the final write completes before runstall drops.
- DONE: load_done=1, runstall=0, sram_en=0, rec_ready=0.
  - load_start in DONE -> INIT: runstall reasserts, rec_count clears and a full re-init occurs.
- load_abort in any state:
  - Next state is IDLE and sram_init drops.
  - Any write already captured still issues on the following cycle.
  - runstall=1 and rec_count is held.
  - If load_abort and load_start are high in the same cycle, abort wins.
- load_start in INIT or LOAD is ignored.
- Duplicate or unordered record addresses are legal; the last write wins.
- rec_valid outside LOAD is ignored, because rec_ready=0.
- A zero-record image is impossible, since at least one rec_last record is required.
- If reset asserts mid-operation, the state returns to IDLE immediately and asynchronously, and outputs take their reset values.

Test Plan:
- Reset then idle -> runstall=1, sram_en=0, sram_init=0, rec_ready=0, rec_count=0.
- load_start; engine model finishes fill 0x0000..0x7FFF -> sram_en mirrors init_en for 32768 cycles, then sram_init_done=1 -> LOAD next cycle, sram_init=0.
- Three back-to-back records (0x0010, 0xDEADBEEF), (0x0011, 0x12345678), (0x7FFF, 0x1, last):
  - Writes appear on consecutive cycles, each 1 cycle after its accept.
  - rec_count=3; load_done=1 and runstall=0 one cycle after the last write.
- Record stream with rec_valid gaps and a duplicate address 0x0020 (0xA then 0xB) -> sram_en low during gaps; the second write carries 0xB; rec_count=2 after rec_last.
- load_abort in LOAD with a record valid that cycle -> rec_ready=0 that cycle, IDLE next, runstall=1; a following load_start restarts init.
- load_start and load_abort in the same cycle in IDLE -> stays IDLE. load_start in DONE -> INIT with runstall=1 and rec_count=0.
